// File: rtl/sdram_arbiter_n_if.sv
// sdram_arbiter_n_if: client request/response bus and SDRAM bridge command bus of the N-client arbiter
interface sdram_arbiter_n_if #(
  parameter int N_CLIENTS = 3,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;
  logic [N_CLIENTS-1:0] cl_rd, cl_wr, cl_lock, cl_ac, cl_wait;
  logic [N_CLIENTS*ADDR_W-1:0] cl_addr;
  logic [N_CLIENTS*DATA_W-1:0] cl_wrdata;
  logic [N_CLIENTS*BE_W-1:0] cl_be;
  logic [DATA_W-1:0] cl_rddata;
  logic [ADDR_W-1:0] bridge_address;
  logic [BE_W-1:0] bridge_byte_enable;
  logic [DATA_W-1:0] bridge_write_data, bridge_read_data;
  logic bridge_read, bridge_write, bridge_acknowledge;
  modport slave (
    input  cl_rd, cl_wr, cl_lock, cl_addr, cl_wrdata, cl_be, bridge_acknowledge, bridge_read_data,
    output cl_ac, cl_wait, cl_rddata, bridge_address, bridge_byte_enable, bridge_write_data, bridge_read, bridge_write
  );
  modport master (
    output cl_rd, cl_wr, cl_lock, cl_addr, cl_wrdata, cl_be, bridge_acknowledge, bridge_read_data,
    input  cl_ac, cl_wait, cl_rddata, bridge_address, bridge_byte_enable, bridge_write_data, bridge_read, bridge_write
  );
endinterface

// File: rtl/sdram_arbiter_n.sv
// sdram_arbiter_n: shares one SDRAM bridge among N clients with fixed or round-robin priority,
// burst lock, a one-cycle recovery slot after each transaction and an acknowledge timeout.
module sdram_arbiter_n #(
  parameter int N_CLIENTS = 3,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  sdram_arbiter_n_if.slave bus,
  output logic [$clog2(N_CLIENTS)-1:0] owner,
  output logic err_timeout,
  output logic err_proto
);
  localparam int BE_W = DATA_W / 8;
  localparam int OW = $clog2(N_CLIENTS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RECOVER = 2'd2;
  logic [1:0] state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rddata_q, rddata_d;
  logic rd_q, rd_d, wr_q, wr_d, err_t_q, err_t_d, err_p_q, err_p_d;
  logic [N_CLIENTS-1:0] ac_q, ac_d, req;
  logic grant, acked, expired, done;
  assign req = bus.cl_rd | bus.cl_wr;
  assign grant = state_q == IDLE && |req;
  assign acked = state_q == ISSUE && bus.bridge_acknowledge;
  assign expired = state_q == ISSUE && !bus.bridge_acknowledge && cnt_q == CW'(TIMEOUT - 1);
  assign done = acked || expired;
  // A locked owner that still requests keeps the bus; otherwise the lowest hit from the scan start wins
  always_comb begin
    win = owner_q;
    if (!(bus.cl_lock[owner_q] && req[owner_q]))
      for (int k = N_CLIENTS - 1; k >= 0; k--)
        if (req[OW'(RR_MODE != 0 ? (int'(ptr_q) + k) % N_CLIENTS : k)])
          win = OW'(RR_MODE != 0 ? (int'(ptr_q) + k) % N_CLIENTS : k);
  end
  always_comb begin
    state_d = grant ? ISSUE : done ? RECOVER : state_q == RECOVER ? IDLE : state_q;
    owner_d = grant ? win : owner_q;
    ptr_d = grant ? (win == OW'(N_CLIENTS - 1) ? '0 : win + 1'b1) : ptr_q;
    addr_d = grant ? bus.cl_addr[win * ADDR_W +: ADDR_W] : addr_q;
    be_d = grant ? bus.cl_be[win * BE_W +: BE_W] : be_q;
    wdata_d = grant ? bus.cl_wrdata[win * DATA_W +: DATA_W] : wdata_q;
    wr_d = grant ? bus.cl_wr[win] : done ? 1'b0 : wr_q;
    rd_d = grant ? bus.cl_rd[win] && !bus.cl_wr[win] : done ? 1'b0 : rd_q;
    cnt_d = (state_q == ISSUE && !done) ? cnt_q + 1'b1 : '0;
    ac_d = done ? N_CLIENTS'(1) << owner_q : '0;
    rddata_d = (acked && rd_q) ? bus.bridge_read_data : rddata_q;
    err_t_d = err_t_q || expired;
    err_p_d = err_p_q || (grant && bus.cl_rd[win] && bus.cl_wr[win]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rddata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ac_q <= '0;
      err_t_q <= 1'b0;
      err_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      rddata_q <= rddata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      ac_q <= ac_d;
      err_t_q <= err_t_d;
      err_p_q <= err_p_d;
    end
  end
  assign bus.cl_ac = ac_q;
  assign bus.cl_wait = req & ~({N_CLIENTS{state_q != IDLE}} & (N_CLIENTS'(1) << owner_q));
  assign bus.cl_rddata = rddata_q;
  assign bus.bridge_address = addr_q;
  assign bus.bridge_byte_enable = be_q;
  assign bus.bridge_write_data = wdata_q;
  assign bus.bridge_read = rd_q;
  assign bus.bridge_write = wr_q;
  assign owner = owner_q;
  assign err_timeout = err_t_q;
  assign err_proto = err_p_q;
endmodule

// File: tb/tb_sdram_arbiter_n.sv
// tb_sdram_arbiter_n: fixed-priority and round-robin arbiters driven by a bridge/client model
// with a scoreboard of expected grants checked on every cl_ac pulse.
module tb_sdram_arbiter_n;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] owner_fx, owner_rr;
  logic et_fx, ep_fx, et_rr, ep_rr;
  sdram_arbiter_n_if #(.N_CLIENTS(3), .ADDR_W(25), .DATA_W(16)) fx ();
  sdram_arbiter_n_if #(.N_CLIENTS(3), .ADDR_W(25), .DATA_W(16)) rr ();
  sdram_arbiter_n #(.N_CLIENTS(3), .ADDR_W(25), .DATA_W(16), .RR_MODE(0), .TIMEOUT(15)) u_fx (
    .clk(clk), .reset(reset), .bus(fx), .owner(owner_fx), .err_timeout(et_fx), .err_proto(ep_fx));
  sdram_arbiter_n #(.N_CLIENTS(3), .ADDR_W(25), .DATA_W(16), .RR_MODE(1), .TIMEOUT(15)) u_rr (
    .clk(clk), .reset(reset), .bus(rr), .owner(owner_rr), .err_timeout(et_rr), .err_proto(ep_rr));
  always #5 clk = ~clk;
  typedef struct { int id; bit rd; logic [15:0] data; } exp_t;
  exp_t sb[$];
  int sb_rr[$];
  int vec = 0, miss = 0, lat = 4, bcnt_fx = 0, bcnt_rr = 0;
  int remain[3], remain_rr[3];
  bit ack_en = 1'b1;
  logic [15:0] last_rd = '0;

  // One clock of the world: check acks against the scoreboard, then update clients and bridges
  task automatic tick();
    exp_t e;
    int r;
    @(negedge clk);
    if (fx.cl_ac != 3'b000) begin
      vec++;
      if (sb.size() == 0) begin
        miss++;
        $display("FAIL fx_ack unexpected cl_ac=%b owner=%0d", fx.cl_ac, owner_fx);
      end else begin
        e = sb.pop_front();
        if (fx.cl_ac !== 3'(1 << e.id) || owner_fx !== 2'(e.id) || (fx.cl_ac & fx.cl_wait) != 3'b000 ||
            (e.rd && fx.cl_rddata !== e.data)) begin
          miss++;
          $display("FAIL fx_ack got cl_ac=%b owner=%0d wait=%b rddata=%h, want client %0d rddata=%h",
                   fx.cl_ac, owner_fx, fx.cl_wait, fx.cl_rddata, e.id, e.data);
        end
        if (e.rd) last_rd = e.data;
      end
      for (int i = 0; i < 3; i++)
        if (fx.cl_ac[i]) begin
          remain[i]--;
          if (remain[i] <= 0) begin fx.cl_rd[i] = 1'b0; fx.cl_wr[i] = 1'b0; fx.cl_lock[i] = 1'b0; end
        end
    end
    if (rr.cl_ac != 3'b000) begin
      vec++;
      r = sb_rr.size() > 0 ? sb_rr.pop_front() : -1;
      if (r < 0 || rr.cl_ac !== 3'(1 << r) || owner_rr !== 2'(r) || (rr.cl_ac & rr.cl_wait) != 3'b000) begin
        miss++;
        $display("FAIL rr_ack got cl_ac=%b owner=%0d, want client %0d", rr.cl_ac, owner_rr, r);
      end
      for (int i = 0; i < 3; i++)
        if (rr.cl_ac[i]) begin
          remain_rr[i]--;
          if (remain_rr[i] <= 0) rr.cl_rd[i] = 1'b0;
        end
    end
    if (fx.bridge_acknowledge) begin fx.bridge_acknowledge = 1'b0; bcnt_fx = 0; end
    else if ((fx.bridge_read || fx.bridge_write) && ack_en) begin
      bcnt_fx++;
      if (bcnt_fx >= lat) begin fx.bridge_acknowledge = 1'b1; fx.bridge_read_data = fx.bridge_address[15:0] + 16'hBDCC; end
    end else bcnt_fx = 0;
    if (rr.bridge_acknowledge) begin rr.bridge_acknowledge = 1'b0; bcnt_rr = 0; end
    else if (rr.bridge_read || rr.bridge_write) begin
      bcnt_rr++;
      if (bcnt_rr >= 2) rr.bridge_acknowledge = 1'b1;
    end else bcnt_rr = 0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vec += 3;
    if (fx.bridge_read !== 1'b0 || fx.bridge_write !== 1'b0 || fx.cl_ac !== 3'b000) begin
      miss++; $display("FAIL rst_strobes rd=%b wr=%b ac=%b, want 0 0 000", fx.bridge_read, fx.bridge_write, fx.cl_ac);
    end
    if (owner_fx !== 2'd0 || fx.cl_rddata !== 16'h0 || fx.bridge_address !== 25'h0) begin
      miss++; $display("FAIL rst_regs owner=%0d rddata=%h addr=%h, want 0", owner_fx, fx.cl_rddata, fx.bridge_address);
    end
    if (et_fx !== 1'b0 || ep_fx !== 1'b0 || rr.bridge_read !== 1'b0 || owner_rr !== 2'd0) begin
      miss++; $display("FAIL rst_err et=%b ep=%b rr_rd=%b rr_owner=%0d, want 0", et_fx, ep_fx, rr.bridge_read, owner_rr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    foreach (remain_rr[i]) remain_rr[i] = 2;
    sb_rr = '{0, 1, 2, 0, 1, 2};
    rr.cl_rd = 3'b111;
    for (int c = 0; c < 80 && sb_rr.size() > 0; c++) tick();
    vec++;
    if (sb_rr.size() != 0) begin miss++; $display("FAIL rr_drain %0d grants missing, want 0", sb_rr.size()); end
    repeat (2) tick();
  endtask

  task automatic test_priority();
    int w2 = 0;
    lat = 4;
    fx.cl_addr[0 +: 25] = 25'h10;
    fx.cl_addr[50 +: 25] = 25'h20;
    sb.push_back('{0, 1'b1, 16'hBDDC});
    sb.push_back('{2, 1'b1, 16'hBDEC});
    remain[0] = 1;
    remain[2] = 1;
    fx.cl_rd = 3'b101;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      tick();
      if (fx.cl_wait[2]) w2++;
    end
    vec += 2;
    if (sb.size() != 0) begin miss++; $display("FAIL prio_drain %0d acks pending, want 0", sb.size()); end
    if (w2 != 6) begin miss++; $display("FAIL prio_wait2 cl_wait[2] high %0d cycles, want 6", w2); end
    repeat (2) tick();
  endtask

  task automatic test_read_latency();
    int hi = 1;
    bit stable = 1'b1;
    lat = 4;
    fx.cl_addr[25 +: 25] = 25'h000123;
    sb.push_back('{1, 1'b1, 16'hBEEF});
    remain[1] = 1;
    fx.cl_rd[1] = 1'b1;
    vec++;
    if (fx.bridge_read !== 1'b0) begin miss++; $display("FAIL rl_pre bridge_read=%b, want 0", fx.bridge_read); end
    tick();
    vec++;
    if (fx.bridge_read !== 1'b1 || fx.bridge_address !== 25'h123) begin
      miss++; $display("FAIL rl_issue bridge_read=%b addr=%h, want 1 000123", fx.bridge_read, fx.bridge_address);
    end
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      tick();
      if (fx.bridge_read) begin hi++; if (fx.bridge_address !== 25'h123) stable = 1'b0; end
    end
    vec++;
    if (sb.size() != 0 || hi != 4 || !stable) begin
      miss++; $display("FAIL rl_hold pending=%0d strobe_cycles=%0d stable=%b, want 0 4 1", sb.size(), hi, stable);
    end
    repeat (2) tick();
  endtask

  task automatic test_write_proto();
    lat = 3;
    fx.cl_addr[0 +: 25] = 25'h1ABCD;
    fx.cl_wrdata[0 +: 16] = 16'hCAFE;
    fx.cl_be[0 +: 2] = 2'b10;
    sb.push_back('{0, 1'b0, 16'h0});
    remain[0] = 1;
    fx.cl_rd[0] = 1'b1;
    fx.cl_wr[0] = 1'b1;
    tick();
    vec += 2;
    if (fx.bridge_write !== 1'b1 || fx.bridge_read !== 1'b0 || ep_fx !== 1'b1) begin
      miss++; $display("FAIL wp_strobe wr=%b rd=%b err_proto=%b, want 1 0 1", fx.bridge_write, fx.bridge_read, ep_fx);
    end
    if (fx.bridge_write_data !== 16'hCAFE || fx.bridge_byte_enable !== 2'b10 || fx.bridge_address !== 25'h1ABCD) begin
      miss++; $display("FAIL wp_fields wdata=%h be=%b addr=%h, want cafe 10 1abcd",
                       fx.bridge_write_data, fx.bridge_byte_enable, fx.bridge_address);
    end
    for (int c = 0; c < 40 && sb.size() > 0; c++) tick();
    vec++;
    if (sb.size() != 0) begin miss++; $display("FAIL wp_drain %0d acks pending, want 0", sb.size()); end
    repeat (2) tick();
  endtask

  task automatic test_lock();
    lat = 2;
    fx.cl_addr[25 +: 25] = 25'h30;
    fx.cl_wrdata[16 +: 16] = 16'h1111;
    fx.cl_be[2 +: 2] = 2'b11;
    fx.cl_addr[0 +: 25] = 25'h40;
    repeat (4) sb.push_back('{1, 1'b0, 16'h0});
    sb.push_back('{0, 1'b1, 16'hBE0C});
    remain[1] = 4;
    fx.cl_wr[1] = 1'b1;
    fx.cl_lock[1] = 1'b1;
    tick();
    remain[0] = 1;
    fx.cl_rd[0] = 1'b1;
    for (int c = 0; c < 80 && sb.size() > 0; c++) tick();
    vec++;
    if (sb.size() != 0) begin miss++; $display("FAIL lock_drain %0d acks pending, want 0", sb.size()); end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit seen = 1'b0;
    lat = 2;
    ack_en = 1'b0;
    fx.cl_addr[0 +: 25] = 25'h50;
    fx.cl_addr[50 +: 25] = 25'h60;
    sb.push_back('{0, 1'b1, last_rd});
    sb.push_back('{2, 1'b1, 16'hBE2C});
    remain[0] = 1;
    remain[2] = 1;
    fx.cl_rd = 3'b101;
    vec++;
    if (et_fx !== 1'b0) begin miss++; $display("FAIL to_pre err_timeout=%b, want 0", et_fx); end
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (fx.bridge_read) hi++;
      seen = fx.cl_ac[0];
    end
    ack_en = 1'b1;
    vec++;
    if (!seen || hi != 15 || et_fx !== 1'b1) begin
      miss++; $display("FAIL to_abort ac_seen=%b strobe_cycles=%0d err_timeout=%b, want 1 15 1", seen, hi, et_fx);
    end
    for (int c = 0; c < 40 && sb.size() > 0; c++) tick();
    vec++;
    if (sb.size() != 0) begin miss++; $display("FAIL to_next %0d acks pending, want 0", sb.size()); end
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    lat = 3;
    ack_en = 1'b0;
    fx.cl_addr[25 +: 25] = 25'h70;
    remain[1] = 1;
    fx.cl_rd[1] = 1'b1;
    tick();
    vec++;
    if (fx.bridge_read !== 1'b1) begin miss++; $display("FAIL ar_issue bridge_read=%b, want 1", fx.bridge_read); end
    #2 reset = 1'b1;
    #1;
    vec++;
    if (fx.bridge_read !== 1'b0 || et_fx !== 1'b0 || owner_fx !== 2'd0) begin
      miss++; $display("FAIL ar_drop bridge_read=%b err_timeout=%b owner=%0d, want 0 0 0", fx.bridge_read, et_fx, owner_fx);
    end
    fx.cl_rd[1] = 1'b0;
    remain[1] = 0;
    tick();
    tick();
    vec++;
    if (fx.cl_ac !== 3'b000 || fx.bridge_read !== 1'b0) begin
      miss++; $display("FAIL ar_hold cl_ac=%b bridge_read=%b, want 000 0", fx.cl_ac, fx.bridge_read);
    end
    reset = 1'b0;
    ack_en = 1'b1;
    sb.push_back('{1, 1'b1, 16'hBE3C});
    remain[1] = 1;
    fx.cl_rd[1] = 1'b1;
    tick();
    vec++;
    if (fx.bridge_read !== 1'b1 || fx.bridge_address !== 25'h70) begin
      miss++; $display("FAIL ar_idle bridge_read=%b addr=%h, want 1 000070", fx.bridge_read, fx.bridge_address);
    end
    for (int c = 0; c < 40 && sb.size() > 0; c++) tick();
    vec++;
    if (sb.size() != 0) begin miss++; $display("FAIL ar_drain %0d acks pending, want 0", sb.size()); end
    repeat (2) tick();
  endtask

  initial begin
    fx.cl_rd = '0; fx.cl_wr = '0; fx.cl_lock = '0; fx.cl_addr = '0; fx.cl_wrdata = '0; fx.cl_be = '0;
    fx.bridge_acknowledge = 1'b0; fx.bridge_read_data = '0;
    rr.cl_rd = '0; rr.cl_wr = '0; rr.cl_lock = '0; rr.cl_addr = '0; rr.cl_wrdata = '0; rr.cl_be = '0;
    rr.bridge_acknowledge = 1'b0; rr.bridge_read_data = '0;
    test_reset();
    test_round_robin();
    test_priority();
    test_read_latency();
    test_write_proto();
    test_lock();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
